// File: rtl/auto_faixa.sv
// auto_faixa -- gate sequencer and automatic range selection for a frequency counter.
//
// Runs the measurement cycle CLEAR -> WAIT -> GATE -> EVAL -> CLEAR.
// The gate opens on one tick_base and closes on the next. When the gate
// closes, the block either moves the time base one step (automatic ranging)
// or loads the display register.
//
// Parameters:
//   SEL_MAX  highest legal time-base select code (shortest gate)
//   SEL_INIT select code loaded at reset
// Ports:
//   clk_sistema_100k  system clock
//   reset_sistema     asynchronous active-low reset
//   tick_base         one-cycle pulse on each edge of the selected time base
//   estouro           one-cycle pulse on a 9999->0000 counter wrap
//   cont_3            most-significant BCD digit of the running count
//   auto_hab          1 = automatic ranging, 0 = manual select
//   sel_manual        time-base select used in manual mode
//   sel_sistema       time-base select to the clock mux (registered)
//   limp              counter clear pulse (registered)
//   hab               counter count enable / gate open (registered)
//   arm               display-register load pulse (registered)
//   faixa_ok          last loaded result is in range (registered)
//   sobre_faixa       last loaded result overflowed at SEL_MAX (registered)
module auto_faixa #(
  parameter int unsigned SEL_MAX  = 5,
  parameter int unsigned SEL_INIT = 5
) (
  input  logic       clk_sistema_100k,
  input  logic       reset_sistema,
  input  logic       tick_base,
  input  logic       estouro,
  input  logic [3:0] cont_3,
  input  logic       auto_hab,
  input  logic [2:0] sel_manual,
  output logic [2:0] sel_sistema,
  output logic       limp,
  output logic       hab,
  output logic       arm,
  output logic       faixa_ok,
  output logic       sobre_faixa
);

  localparam logic [2:0] SEL_MAX_C  = 3'(SEL_MAX);
  localparam logic [2:0] SEL_INIT_C = 3'(SEL_INIT);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    WAIT  = 2'd1,
    GATE  = 2'd2,
    EVAL  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       sticky_q, sticky_d;
  logic [2:0] sel_d;
  logic       limp_d, hab_d, arm_d, ok_d, sobre_d;
  logic       ovf;

  always_ff @(posedge clk_sistema_100k or negedge reset_sistema) begin
    if (!reset_sistema) begin
      state_q     <= CLEAR;
      sticky_q    <= 1'b0;
      sel_sistema <= SEL_INIT_C;
      limp        <= 1'b0;
      hab         <= 1'b0;
      arm         <= 1'b0;
      faixa_ok    <= 1'b0;
      sobre_faixa <= 1'b0;
    end else begin
      state_q     <= state_d;
      sticky_q    <= sticky_d;
      sel_sistema <= sel_d;
      limp        <= limp_d;
      hab         <= hab_d;
      arm         <= arm_d;
      faixa_ok    <= ok_d;
      sobre_faixa <= sobre_d;
    end
  end

  // Every output is registered, so each one is computed on the transition
  // into the state where it must be visible: the EVAL decision is taken on
  // the closing tick, and hab rises on the opening tick.
  always_comb begin
    state_d  = state_q;
    sticky_d = sticky_q;
    sel_d    = sel_sistema;
    limp_d   = 1'b0;
    hab_d    = 1'b0;
    arm_d    = 1'b0;
    ok_d     = faixa_ok;
    sobre_d  = sobre_faixa;
    // An estouro that arrives together with the closing tick still counts.
    ovf      = sticky_q | estouro;

    case (state_q)
      CLEAR: begin
        sticky_d = 1'b0;
        // CLEAR held by reset has limp=0. It spends one extra cycle here so
        // that the first cycle after release is a CLEAR with limp=1.
        if (!limp) begin
          limp_d = 1'b1;
        end else begin
          state_d = WAIT;
          if (!auto_hab)
            sel_d = (sel_manual > SEL_MAX_C) ? SEL_MAX_C : sel_manual;
        end
      end

      WAIT: begin
        if (tick_base) begin
          state_d = GATE;
          hab_d   = 1'b1;
        end
      end

      GATE: begin
        if (estouro)
          sticky_d = 1'b1;
        if (!tick_base) begin
          hab_d = 1'b1;
        end else begin
          state_d = EVAL;
          if (auto_hab) begin
            if (ovf) begin
              if (sel_sistema < SEL_MAX_C) begin
                sel_d = sel_sistema + 3'd1;
              end else begin
                arm_d   = 1'b1;
                ok_d    = 1'b0;
                sobre_d = 1'b1;
              end
            end else if (cont_3 == 4'd0 && sel_sistema != 3'd0) begin
              sel_d = sel_sistema - 3'd1;
            end else begin
              arm_d   = 1'b1;
              ok_d    = 1'b1;
              sobre_d = 1'b0;
            end
          end else begin
            arm_d   = 1'b1;
            ok_d    = !ovf;
            sobre_d = ovf;
          end
        end
      end

      EVAL: begin
        state_d  = CLEAR;
        limp_d   = 1'b1;
        sticky_d = 1'b0;
      end

      default: state_d = CLEAR;
    endcase
  end

endmodule

// File: tb/tb_auto_faixa.sv
// tb_auto_faixa -- directed self-checking bench for auto_faixa.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_auto_faixa;

  logic       clk_sistema_100k;
  logic       reset_sistema;
  logic       tick_base;
  logic       estouro;
  logic [3:0] cont_3;
  logic       auto_hab;
  logic [2:0] sel_manual;
  logic [2:0] sel_sistema;
  logic       limp, hab, arm, faixa_ok, sobre_faixa;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_ok    = 0;
  int exp_sobre = 0;

  auto_faixa #(.SEL_MAX(5), .SEL_INIT(5)) dut (
    .clk_sistema_100k (clk_sistema_100k),
    .reset_sistema    (reset_sistema),
    .tick_base        (tick_base),
    .estouro          (estouro),
    .cont_3           (cont_3),
    .auto_hab         (auto_hab),
    .sel_manual       (sel_manual),
    .sel_sistema      (sel_sistema),
    .limp             (limp),
    .hab              (hab),
    .arm              (arm),
    .faixa_ok         (faixa_ok),
    .sobre_faixa      (sobre_faixa)
  );

  initial clk_sistema_100k = 1'b0;
  always #5 clk_sistema_100k = ~clk_sistema_100k;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_sistema_100k);
    #1;
  endtask

  // Runs one full measurement cycle, starting and ending in WAIT.
  // e_sel is the select expected in EVAL; e_sel2 is the select expected after CLEAR.
  task automatic gate(input string tag, input bit ovf_mid, input bit ovf_end,
                      input logic [3:0] c3, input bit e_arm,
                      input int e_sel, input int e_sel2,
                      input int e_ok, input int e_sobre);
    int sel0;
    sel0 = sel_sistema;
    estouro = 1'b1;                     // estouro in WAIT has no effect
    step();
    estouro = 1'b0;
    check_eq({tag, ".wait_hab"}, hab, 0);
    step();
    tick_base = 1'b1;
    step();
    tick_base = 1'b0;
    check_eq({tag, ".hab_rise"}, hab, 1);
    step();
    if (ovf_mid) estouro = 1'b1;
    step();
    estouro = 1'b0;
    step();
    check_eq({tag, ".gate_sel"}, sel_sistema, sel0);
    tick_base = 1'b1;
    estouro   = ovf_end;
    cont_3    = c3;
    step();                             // EVAL; tick_base stays high and is ignored
    estouro = 1'b0;
    check_eq({tag, ".hab_fall"}, hab, 0);
    check_eq({tag, ".arm"}, arm, e_arm);
    check_eq({tag, ".sel"}, sel_sistema, e_sel);
    if (e_arm) begin
      exp_ok    = e_ok;
      exp_sobre = e_sobre;
    end
    check_eq({tag, ".faixa_ok"}, faixa_ok, exp_ok);
    check_eq({tag, ".sobre"}, sobre_faixa, exp_sobre);
    step();                             // CLEAR; tick_base still high
    check_eq({tag, ".limp"}, limp, 1);
    check_eq({tag, ".arm_1cyc"}, arm, 0);
    step();                             // WAIT
    tick_base = 1'b0;
    check_eq({tag, ".limp_1cyc"}, limp, 0);
    check_eq({tag, ".hab_wait"}, hab, 0);
    check_eq({tag, ".sel_clr"}, sel_sistema, e_sel2);
  endtask

  initial begin
    reset_sistema = 1'b0;
    tick_base     = 1'b0;
    estouro       = 1'b0;
    cont_3        = 4'd3;
    auto_hab      = 1'b1;
    sel_manual    = 3'd0;
    #23;
    check_eq("rst.sel", sel_sistema, 5);
    check_eq("rst.limp", limp, 0);
    check_eq("rst.hab", hab, 0);
    check_eq("rst.arm", arm, 0);
    check_eq("rst.ok", faixa_ok, 0);
    check_eq("rst.sobre", sobre_faixa, 0);
    @(negedge clk_sistema_100k);
    reset_sistema = 1'b1;
    step();
    check_eq("rel.limp", limp, 1);
    step();
    check_eq("rel.limp_off", limp, 0);

    // Overflow at SEL_MAX: out of range, select held.
    gate("ovf_max", 1, 0, 4'd3, 1, 5, 5, 0, 1);
    // Downranging on leading zero, saturating at 0.
    gate("down4", 0, 0, 4'd0, 0, 4, 4, 0, 0);
    gate("down3", 0, 0, 4'd0, 0, 3, 3, 0, 0);
    gate("down2", 0, 0, 4'd0, 0, 2, 2, 0, 0);
    gate("down1", 0, 0, 4'd0, 0, 1, 1, 0, 0);
    gate("down0", 0, 0, 4'd0, 0, 0, 0, 0, 0);
    gate("sat0", 0, 0, 4'd0, 1, 0, 0, 1, 0);
    // Uprange back to 2, then an estouro coincident with the closing tick.
    gate("up1", 1, 0, 4'd0, 0, 1, 1, 0, 0);
    gate("up2", 1, 0, 4'd0, 0, 2, 2, 0, 0);
    gate("up_end", 0, 1, 4'd0, 0, 3, 3, 0, 0);
    gate("inrange", 0, 0, 4'd5, 1, 3, 3, 1, 0);

    // Manual mode: selected in WAIT, applies at this EVAL and the following CLEAR.
    auto_hab   = 1'b0;
    sel_manual = 3'd7;
    gate("man_clamp", 0, 0, 4'd0, 1, 3, 5, 1, 0);
    gate("man_c0", 0, 0, 4'd0, 1, 5, 5, 1, 0);
    gate("man_ovf", 1, 0, 4'd0, 1, 5, 5, 0, 1);
    sel_manual = 3'd2;
    gate("man_sel2", 0, 0, 4'd0, 1, 5, 2, 1, 0);
    gate("man_end", 0, 1, 4'd9, 1, 2, 2, 0, 1);

    // Reset asserted while the gate is open.
    tick_base = 1'b1;
    step();
    tick_base = 1'b0;
    check_eq("mid.hab", hab, 1);
    #2;
    reset_sistema = 1'b0;
    #1;
    check_eq("mid.hab_async", hab, 0);
    check_eq("mid.sel", sel_sistema, 5);
    check_eq("mid.ok", faixa_ok, 0);
    check_eq("mid.sobre", sobre_faixa, 0);
    tick_base = 1'b1;
    estouro   = 1'b1;
    step();
    step();
    check_eq("mid.arm", arm, 0);
    check_eq("mid.limp", limp, 0);
    tick_base = 1'b0;
    estouro   = 1'b0;
    @(negedge clk_sistema_100k);
    reset_sistema = 1'b1;
    step();
    check_eq("mid.rel_limp", limp, 1);
    check_eq("mid.rel_arm", arm, 0);
    step();
    check_eq("mid.rel_limp_off", limp, 0);
    check_eq("mid.rel_sel", sel_sistema, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
